// File: rtl/tile_spawn_controller.sv
// Places one new 2048 tile per request: random sampling of the frozen empty-cell
// mask, with a deterministic wrap-around scan once the random attempts run out.
module tile_spawn_controller #(
    parameter int MAX_TRIES   = 4,
    parameter int FOUR_THRESH = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] empty_mask,
    input  logic [31:0] rand_in,
    output logic        busy,
    output logic        wr_en,
    output logic [3:0]  wr_pos,
    output logic [3:0]  wr_exp,
    output logic        done,
    output logic        board_full
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CHECK  = 3'd1,
        S_SAMPLE = 3'd2,
        S_SCAN   = 3'd3,
        S_WRITE  = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    // Exponent 2 ("4" tile) when the random nibble falls under the threshold.
    function automatic logic [3:0] tile_exp(input logic [3:0] nib);
        logic [3:0] e;
        if ({1'b0, nib} < 5'(FOUR_THRESH)) begin
            e = 4'd2;
        end else begin
            e = 4'd1;
        end
        return e;
    endfunction

    state_t      state_r, state_s;
    logic [15:0] mask_q_r, mask_q_s;
    logic [3:0]  tries_r, tries_s;
    logic [3:0]  scan_ptr_r, scan_ptr_s;
    logic [3:0]  wr_pos_r, wr_pos_s;
    logic [3:0]  wr_exp_r, wr_exp_s;
    logic        board_full_r, board_full_s;
    logic [3:0]  cand_s;
    logic        rand_unused_s;

    assign cand_s        = rand_in[3:0];
    assign rand_unused_s = ^rand_in[31:8];

    // State register and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r      <= S_IDLE;
            mask_q_r     <= 16'h0000;
            tries_r      <= 4'd0;
            scan_ptr_r   <= 4'd0;
            wr_pos_r     <= 4'd0;
            wr_exp_r     <= 4'd0;
            board_full_r <= 1'b0;
        end else begin
            state_r      <= state_s;
            mask_q_r     <= mask_q_s;
            tries_r      <= tries_s;
            scan_ptr_r   <= scan_ptr_s;
            wr_pos_r     <= wr_pos_s;
            wr_exp_r     <= wr_exp_s;
            board_full_r <= board_full_s;
        end
    end

    // Next-state and next-datapath decode.
    always_comb begin
        state_s      = state_r;
        mask_q_s     = mask_q_r;
        tries_s      = tries_r;
        scan_ptr_s   = scan_ptr_r;
        wr_pos_s     = wr_pos_r;
        wr_exp_s     = wr_exp_r;
        board_full_s = board_full_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    mask_q_s     = empty_mask;
                    tries_s      = 4'd0;
                    board_full_s = 1'b0;
                    state_s      = S_CHECK;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CHECK: begin
                if (mask_q_r == 16'h0000) begin
                    board_full_s = 1'b1;
                    state_s      = S_DONE;
                end else begin
                    state_s = S_SAMPLE;
                end
            end
            S_SAMPLE: begin
                if (mask_q_r[cand_s]) begin
                    wr_pos_s = cand_s;
                    wr_exp_s = tile_exp(rand_in[7:4]);
                    state_s  = S_WRITE;
                end else if (tries_r == 4'(MAX_TRIES - 1)) begin
                    // Scan starts just past the last rejected candidate.
                    scan_ptr_s = cand_s + 4'd1;
                    state_s    = S_SCAN;
                end else begin
                    tries_s = tries_r + 4'd1;
                end
            end
            S_SCAN: begin
                if (mask_q_r[scan_ptr_r]) begin
                    wr_pos_s = scan_ptr_r;
                    wr_exp_s = tile_exp(rand_in[7:4]);
                    state_s  = S_WRITE;
                end else begin
                    scan_ptr_s = scan_ptr_r + 4'd1;
                end
            end
            S_WRITE: state_s = S_DONE;
            S_DONE:  state_s = S_IDLE;
            default: state_s = S_IDLE;
        endcase
    end

    assign busy       = (state_r != S_IDLE);
    assign wr_en      = (state_r == S_WRITE);
    assign done       = (state_r == S_DONE);
    assign wr_pos     = wr_pos_r;
    assign wr_exp     = wr_exp_r;
    assign board_full = board_full_r;

endmodule

// File: tb/tb_tile_spawn_controller.sv
// Randomized scoreboard bench for tile_spawn_controller against a rule-level
// placement model.
module tb_tile_spawn_controller;

    localparam int MAX_TRIES   = 4;
    localparam int FOUR_THRESH = 2;
    localparam int RV_LEN      = 40;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [15:0] empty_mask = 16'h0000;
    logic [31:0] rand_in = 32'h0;
    logic        busy, wr_en, done, board_full;
    logic [3:0]  wr_pos, wr_exp;

    tile_spawn_controller #(.MAX_TRIES(MAX_TRIES), .FOUR_THRESH(FOUR_THRESH)) dut (
        .clk(clk), .rst(rst), .start(start), .empty_mask(empty_mask),
        .rand_in(rand_in), .busy(busy), .wr_en(wr_en), .wr_pos(wr_pos),
        .wr_exp(wr_exp), .done(done), .board_full(board_full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       full;
        logic [3:0] pos;
        logic [3:0] exp;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] rv[RV_LEN];
    int          checks = 0;
    int          errors = 0;
    int          wr_cnt = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    function automatic logic [3:0] four_or_two(input logic [31:0] r);
        return (int'(r[7:4]) < FOUR_THRESH) ? 4'd2 : 4'd1;
    endfunction

    // Attempt t (random or scan) looks at the rand word present at edge 2+t after start.
    function automatic void model(input logic [15:0] m, output exp_t e, output int n);
        logic [3:0] c;
        int         idx;
        e.full = (m == 16'h0000);
        e.pos  = 4'd0;
        e.exp  = 4'd0;
        n      = 0;
        idx    = 2;
        c      = 4'd0;
        if (e.full) return;
        for (int t = 0; t < MAX_TRIES; t++) begin
            c = rv[idx][3:0];
            n++;
            if (m[c]) begin
                e.pos = c;
                e.exp = four_or_two(rv[idx]);
                return;
            end
            idx++;
        end
        c = c + 4'd1;
        for (int s = 0; s < 16; s++) begin
            n++;
            if (m[c]) begin
                e.pos = c;
                e.exp = four_or_two(rv[idx]);
                return;
            end
            c = c + 4'd1;
            idx++;
        end
    endfunction

    // Monitor: checks every write and completion against the scoreboard queue.
    always @(negedge clk) begin
        if (rst) begin
            if (wr_en) begin
                if (exp_q.size() == 0 || exp_q[0].full) begin
                    chk("unexpected_wr_en", 32'd1, 32'd0);
                end else begin
                    chk("wr_pos", 32'(wr_pos), 32'(exp_q[0].pos));
                    chk("wr_exp", 32'(wr_exp), 32'(exp_q[0].exp));
                end
                wr_cnt++;
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'd1, 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("board_full", 32'(board_full), 32'(e.full));
                    chk("writes_per_request", 32'(wr_cnt), e.full ? 32'd0 : 32'd1);
                end
                wr_cnt = 0;
            end
        end
    end

    task automatic fill_rand();
        for (int i = 0; i < RV_LEN; i++) rv[i] = $urandom;
    endtask

    task automatic run_txn(input logic [15:0] mask, input logic noisy);
        exp_t e;
        int   n, wr_k;
        logic got_done;
        model(mask, e, n);
        exp_q.push_back(e);
        @(negedge clk);
        start = 1'b1; empty_mask = mask; rand_in = rv[0];
        got_done = 1'b0; wr_k = -1;
        for (int k = 1; k < RV_LEN; k++) begin
            @(negedge clk);
            if (wr_en && wr_k < 0) wr_k = k;
            if (done) begin
                got_done = 1'b1;
                break;
            end
            rand_in = rv[k];
            start   = noisy ? ($urandom_range(0, 2) == 0) : 1'b0;
            if (noisy) empty_mask = 16'($urandom);
        end
        start = 1'b0;
        if (!got_done) begin
            chk("done_timeout", 32'd0, 32'd1);
            exp_q.delete();
        end else if (!e.full && n == 1) begin
            chk("first_hit_latency", 32'(wr_k), 32'd3);
        end else if (!e.full) begin
            chk("wr_en_within_bound", 32'(wr_k >= 3 && wr_k <= 3 + MAX_TRIES + 15), 32'd1);
        end
    endtask

    initial begin
        #1;
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_wr_en", 32'(wr_en), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_board_full", 32'(board_full), 32'd0);
        chk("reset_wr_pos", 32'(wr_pos), 32'd0);
        chk("reset_wr_exp", 32'(wr_exp), 32'd0);
        @(negedge clk); rst = 1'b1;

        // First-sample hit: pos 5, "2" tile.
        fill_rand(); rv[2] = 32'hABCD_0095;
        run_txn(16'h0020, 1'b0);
        // Four tile from a full-empty board.
        fill_rand(); rv[2] = 32'h1234_001A;
        run_txn(16'hFFFF, 1'b0);
        // Four misses at cell 14, then wrap-around scan 15,0,1,2.
        fill_rand();
        for (int i = 2; i < 2 + MAX_TRIES; i++) rv[i] = {rv[i][31:4], 4'hE};
        run_txn(16'h0004, 1'b0);
        // Full board.
        fill_rand();
        run_txn(16'h0000, 1'b0);
        // Start re-pulsed and mask flipped mid-request.
        fill_rand();
        for (int i = 2; i < 2 + MAX_TRIES; i++) rv[i] = {rv[i][31:4], 4'h3};
        run_txn(16'h0100, 1'b1);

        // Reset while in SAMPLE: outputs clear at once and nothing follows.
        fill_rand();
        @(negedge clk); start = 1'b1; empty_mask = 16'hFFFF; rand_in = rv[0];
        @(negedge clk); start = 1'b0; rand_in = rv[1];
        @(negedge clk);
        chk("busy_before_reset", 32'(busy), 32'd1);
        rst = 1'b0;
        #1;
        chk("midreset_busy", 32'(busy), 32'd0);
        chk("midreset_wr_en", 32'(wr_en), 32'd0);
        chk("midreset_done", 32'(done), 32'd0);
        chk("midreset_board_full", 32'(board_full), 32'd0);
        chk("midreset_wr_pos", 32'(wr_pos), 32'd0);
        chk("midreset_wr_exp", 32'(wr_exp), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (4) @(negedge clk);
        chk("idle_after_reset", 32'(busy), 32'd0);
        fill_rand(); rv[2] = 32'h0000_0095;
        run_txn(16'h0020, 1'b0);

        // Randomized requests.
        for (int t = 0; t < 150; t++) begin
            logic [15:0] m;
            fill_rand();
            case ($urandom_range(0, 3))
                0: m = 16'h0000;
                1: m = 16'h0001 << $urandom_range(0, 15);
                2: m = 16'($urandom) & 16'($urandom) & 16'($urandom);
                default: m = 16'($urandom);
            endcase
            run_txn(m, 1'($urandom_range(0, 1)));
        end

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule
